// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - memory-mapped UART responder with TX/RX byte FIFOs
module uart_mmio_responder #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int TXPW = $clog2(TX_DEPTH);
  localparam int RXPW = $clog2(RX_DEPTH);
  localparam int TXCW = TXPW + 1;
  localparam int RXCW = RXPW + 1;
  localparam logic [TXCW-1:0] TX_FULL = TXCW'(TX_DEPTH);
  localparam logic [RXCW-1:0] RX_FULL = RXCW'(RX_DEPTH);

  // register offsets, word index addr[4:2]
  localparam logic [2:0] REG_TX_STAT = 3'd0;
  localparam logic [2:0] REG_RX_STAT = 3'd1;
  localparam logic [2:0] REG_TX_DATA = 3'd2;
  localparam logic [2:0] REG_RX_DATA = 3'd3;
  localparam logic [2:0] REG_FLAGS   = 3'd4;

  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TXPW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TXCW-1:0] tx_count_q, tx_count_d;
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RXPW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RXCW-1:0] rx_count_q, rx_count_d;
  logic            tx_drop_q, rx_ovf_q;
  logic [31:0]     rdata_q, rdata_d;

  logic hit, wr, rd;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_drop_set;
  logic rx_push, rx_pop, rx_ovf_set;
  logic flags_clr;

  // only the low byte of a store carries TX data
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:8]};

  // decode and FIFO handshake strobes
  always_comb begin
    hit         = (addr[31:4] == 28'h8000_000) || (addr == 32'h8000_0010);
    wr          = we && hit;
    rd          = re && !we && hit;
    tx_full     = (tx_count_q == TX_FULL);
    tx_empty    = (tx_count_q == '0);
    rx_full     = (rx_count_q == RX_FULL);
    rx_empty    = (rx_count_q == '0);
    tx_pop      = !tx_empty && DataInReady;
    tx_push     = 1'b0;
    tx_drop_set = 1'b0;
    if (wr && addr[4:2] == REG_TX_DATA) begin
      if (!tx_full || tx_pop) tx_push = 1'b1;
      else                    tx_drop_set = 1'b1;
    end
    rx_pop      = rd && (addr[4:2] == REG_RX_DATA) && !rx_empty;
    rx_push     = 1'b0;
    rx_ovf_set  = 1'b0;
    if (DataOutValid) begin
      if (!rx_full || rx_pop) rx_push = 1'b1;
      else                    rx_ovf_set = 1'b1;
    end
    flags_clr   = wr && (addr[4:2] == REG_FLAGS);
  end

  // next occupancy counts
  always_comb begin
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
  end

  // load data: status sampled before this cycle's FIFO updates; misses and we+re return 0
  always_comb begin
    rdata_d = rdata_q;
    if (re || we) begin
      rdata_d = '0;
      if (rd) begin
        case (addr[4:2])
          REG_TX_STAT: rdata_d = {31'b0, !tx_full};
          REG_RX_STAT: rdata_d = {31'b0, !rx_empty};
          REG_RX_DATA: rdata_d = rx_empty ? 32'h0 : {24'b0, rx_mem_q[rx_rptr_q]};
          REG_FLAGS:   rdata_d = {30'b0, rx_ovf_q, tx_drop_q};
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  // FIFO storage writes; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= DataOut;
  end

  // pointers, counts, sticky flags and load data
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_drop_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      // a same-cycle overflow wins over a clear so no drop goes unreported
      tx_drop_q  <= tx_drop_set || (tx_drop_q && !flags_clr);
      rx_ovf_q   <= rx_ovf_set  || (rx_ovf_q  && !flags_clr);
      rdata_q    <= rdata_d;
    end
  end

  assign rdata        = rdata_q;
  assign DataIn       = tx_mem_q[tx_rptr_q];
  assign DataInValid  = !tx_empty;
  assign DataOutReady = 1'b1;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb/tb_uart_mmio_responder.sv - directed self-checking bench for uart_mmio_responder
module tb_uart_mmio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [7:0]  DataOut = '0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;

  int n_cmp = 0;
  int n_bad = 0;

  uart_mmio_responder #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .DataIn(DataIn), .DataInValid(DataInValid),
    .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady)
  );

  always #5 clk = ~clk;

  task automatic cpu_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    re   = 1'b1;
    @(negedge clk);
    re   = 1'b0;
    d    = rdata;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    DataOut      = b;
    DataOutValid = 1'b1;
    @(negedge clk);
    DataOutValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if (DataInValid !== 1'b0) begin n_bad++; $display("FAIL reset_div got %b want 0", DataInValid); end
    n_cmp++; if (DataOutReady !== 1'b1) begin n_bad++; $display("FAIL reset_dor got %b want 1", DataOutReady); end
    cpu_load(32'h8000_0000, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL reset_tx_stat got %h want 1", d); end
    cpu_load(32'h8000_0004, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_rx_stat got %h want 0", d); end
    cpu_load(32'h8000_0000, d);
    cpu_load(32'h9000_0000, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL miss_rdata got %h want 0", d); end
    cpu_store(32'h8000_0000, 32'h5A);
    n_cmp++; if (DataInValid !== 1'b0) begin n_bad++; $display("FAIL store_stat_ignored got %b want 0", DataInValid); end
  endtask

  task automatic test_tx_basic();
    DataInReady = 1'b0;
    cpu_store(32'h8000_0008, 32'hFFFF_FF41);
    cpu_store(32'h8000_0008, 32'h0000_0042);
    n_cmp++; if (DataInValid !== 1'b1) begin n_bad++; $display("FAIL tx_valid got %b want 1", DataInValid); end
    n_cmp++; if (DataIn !== 8'h41) begin n_bad++; $display("FAIL tx_head0 got %h want 41", DataIn); end
    DataInReady = 1'b1;
    @(negedge clk);
    DataInReady = 1'b0;
    n_cmp++; if (DataIn !== 8'h42 || DataInValid !== 1'b1) begin n_bad++; $display("FAIL tx_head1 got %h/%b want 42/1", DataIn, DataInValid); end
    DataInReady = 1'b1;
    @(negedge clk);
    DataInReady = 1'b0;
    n_cmp++; if (DataInValid !== 1'b0) begin n_bad++; $display("FAIL tx_drained got %b want 0", DataInValid); end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    int got;
    DataInReady = 1'b0;
    for (int i = 0; i < 9; i++) cpu_store(32'h8000_0008, 32'h10 + i);
    cpu_load(32'h8000_0000, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL txfull_stat got %h want 0", d); end
    cpu_load(32'h8000_0010, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL tx_drop got %h want 1", d); end
    got = 0;
    DataInReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (DataInValid === 1'b1) begin
        n_cmp++;
        if (DataIn !== 8'(8'h10 + got)) begin n_bad++; $display("FAIL tx_drain[%0d] got %h want %h", got, DataIn, 8'(8'h10 + got)); end
        got++;
      end
      @(negedge clk);
    end
    DataInReady = 1'b0;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL tx_drain_count got %0d want 8", got); end
    cpu_store(32'h8000_0010, 32'h0);
    cpu_load(32'h8000_0010, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL flag_clear got %h want 0", d); end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    rx_byte(8'h55);
    rx_byte(8'hAA);
    cpu_load(32'h8000_0004, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL rx_stat1 got %h want 1", d); end
    cpu_load(32'h8000_000C, d);
    n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL rx_pop0 got %h want 55", d); end
    cpu_load(32'h8000_000C, d);
    n_cmp++; if (d !== 32'hAA) begin n_bad++; $display("FAIL rx_pop1 got %h want aa", d); end
    cpu_load(32'h8000_0004, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_stat0 got %h want 0", d); end
    cpu_load(32'h8000_000C, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_empty_pop got %h want 0", d); end
    // empty pop with same-cycle push: byte is stored, not returned
    @(negedge clk);
    addr = 32'h8000_000C; re = 1'b1; DataOut = 8'h99; DataOutValid = 1'b1;
    @(negedge clk);
    re = 1'b0; DataOutValid = 1'b0;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rx_empty_push got %h want 0", rdata); end
    cpu_load(32'h8000_000C, d);
    n_cmp++; if (d !== 32'h99) begin n_bad++; $display("FAIL rx_stored got %h want 99", d); end
  endtask

  task automatic test_rx_full();
    logic [31:0] d;
    logic [7:0] exp_b [8];
    for (int i = 0; i < 8; i++) rx_byte(8'h60 + 8'(i));
    @(negedge clk);
    addr = 32'h8000_000C; re = 1'b1; DataOut = 8'h77; DataOutValid = 1'b1;
    @(negedge clk);
    re = 1'b0; DataOutValid = 1'b0;
    n_cmp++; if (rdata !== 32'h60) begin n_bad++; $display("FAIL rxfull_pop got %h want 60", rdata); end
    cpu_load(32'h8000_0010, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_no_ovf got %h want 0", d); end
    rx_byte(8'h88);
    cpu_load(32'h8000_0010, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL rx_ovf got %h want 2", d); end
    cpu_store(32'h8000_0010, 32'hDEAD_BEEF);
    cpu_load(32'h8000_0010, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_ovf_clear got %h want 0", d); end
    exp_b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h77};
    for (int i = 0; i < 8; i++) begin
      cpu_load(32'h8000_000C, d);
      n_cmp++; if (d !== {24'b0, exp_b[i]}) begin n_bad++; $display("FAIL rx_order[%0d] got %h want %h", i, d, exp_b[i]); end
    end
    cpu_load(32'h8000_000C, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rx_after_drain got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    DataInReady = 1'b0;
    for (int i = 0; i < 3; i++) cpu_store(32'h8000_0008, 32'hC0 + i);
    rx_byte(8'h11);
    rx_byte(8'h22);
    n_cmp++; if (DataInValid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_div got %b want 1", DataInValid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (DataInValid !== 1'b0) begin n_bad++; $display("FAIL rst_div got %b want 0", DataInValid); end
    cpu_load(32'h8000_0004, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_rx_stat got %h want 0", d); end
    cpu_load(32'h8000_0000, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL rst_tx_stat got %h want 1", d); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_basic();
    test_rx_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
